// File: rtl/snn_pkg.sv
// Shared configuration and types for the SNN core time-step sequencer.
package snn_pkg;

  function automatic int sel_width(input int blocks);
    return (blocks > 1) ? $clog2(blocks) : 1;
  endfunction

  function automatic int frame_bytes(input int bits);
    return (bits + 7) / 8;
  endfunction

  localparam int N  = 4;
  localparam int T  = 1;
  localparam int TS = 239;
  localparam int TA = sel_width(T);
  localparam int NN = frame_bytes(N * T);
  localparam int NU = $clog2(TS + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, EMIT} sched_state_t;

  typedef logic [N*T-1:0] spike_frame_t;

endpackage

// File: rtl/snn_step_scheduler_if.sv
// AXI4-Stream spike-frame channel between the step scheduler and its consumer.
interface snn_step_scheduler_if #(
  parameter int NN = snn_pkg::NN,
  parameter int NU = snn_pkg::NU
) ();

  logic [8*NN-1:0] tdata;
  logic [NU-1:0]   tuser;
  logic            tvalid;
  logic            tready;
  logic            tlast;

  modport master (output tdata, tuser, tvalid, tlast, input tready);
  modport slave  (input tdata, tuser, tvalid, tlast, output tready);

endinterface

// File: rtl/snn_frame_packer.sv
// Places the collected N*T spike bits into the low end of a byte-wide tdata word.
module snn_frame_packer #(
  parameter int N  = snn_pkg::N,
  parameter int T  = snn_pkg::T,
  parameter int NN = snn_pkg::NN
) (
  input  logic [N*T-1:0]  spikes,
  output logic [8*NN-1:0] tdata
);

  // NOTE: assign every combinational output a default first so no path can infer a latch.
  always_comb begin
    tdata            = '0;
    tdata[N*T-1:0]   = spikes;
  end

endmodule

// File: rtl/snn_step_scheduler.sv
// Time-step sequencer: per step, updates blocks 0..T-1 then streams one spike frame.
// Optional abort support is compiled in with SNN_STEP_SCHEDULER_ABORT_EN.
module snn_step_scheduler
  import snn_pkg::*;
#(
  parameter int N  = snn_pkg::N,
  parameter int T  = snn_pkg::T,
  parameter int TS = snn_pkg::TS,
  parameter int TA = sel_width(T),
  parameter int NN = frame_bytes(N * T),
  parameter int NU = $clog2(TS + 1)
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic [TA-1:0]       blk_sel,
  output logic                blk_go,
  input  logic                blk_done,
  input  logic [N-1:0]        blk_spikes,
`ifdef SNN_STEP_SCHEDULER_ABORT_EN
  input  logic                abort,
  output logic                aborted,
`endif
  snn_step_scheduler_if.master m_axis
);

  typedef logic [N*T-1:0] frame_t;

  sched_state_t  state_q, state_d;
  logic [NU-1:0] step_q, step_d;
  logic [TA-1:0] blk_sel_q, blk_sel_d;
  frame_t        spike_q, spike_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          go_q, go_d;
  logic          tvalid_q, tvalid_d;
  logic          tlast_q, tlast_d;
  logic          abort_pend_q, abort_pend_d;
  logic          abort_req;
  logic          last_blk;
  logic          last_step;
  logic [8*NN-1:0] tdata_w;

`ifdef SNN_STEP_SCHEDULER_ABORT_EN
  logic aborted_q, aborted_d;
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  assign last_blk  = (blk_sel_q == TA'(T - 1));
  assign last_step = (step_q == NU'(TS - 1));

  always_comb begin
    state_d      = state_q;
    step_d       = step_q;
    blk_sel_d    = blk_sel_q;
    spike_d      = spike_q;
    tlast_d      = tlast_q;
    abort_pend_d = abort_pend_q;
    done_d       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d      = ISSUE;
          step_d       = '0;
          blk_sel_d    = '0;
          spike_d      = '0;
          abort_pend_d = 1'b0;
        end
      end
      ISSUE: begin
        if (abort_req) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (abort_req) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (blk_done) begin
          spike_d[int'(blk_sel_q)*N +: N] = blk_spikes;
          if (last_blk) begin
            state_d = EMIT;
            tlast_d = last_step;
          end else begin
            blk_sel_d = blk_sel_q + TA'(1);
            state_d   = ISSUE;
          end
        end
      end
      EMIT: begin
        // An abort seen while stalled turns the pending frame into the final one.
        if (abort_req) begin
          abort_pend_d = 1'b1;
          tlast_d      = 1'b1;
        end
        if (m_axis.tready) begin
          tlast_d = 1'b0;
          if (last_step || abort_req || abort_pend_q) begin
            state_d      = IDLE;
            done_d       = 1'b1;
            abort_pend_d = 1'b0;
          end else begin
            step_d    = step_q + NU'(1);
            blk_sel_d = '0;
            spike_d   = '0;
            state_d   = ISSUE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next state so they line up with it.
    busy_d   = (state_d != IDLE);
    go_d     = (state_d == ISSUE);
    tvalid_d = (state_d == EMIT);
`ifdef SNN_STEP_SCHEDULER_ABORT_EN
    aborted_d = done_d && (abort_req || abort_pend_q);
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q      <= IDLE;
      step_q       <= '0;
      blk_sel_q    <= '0;
      spike_q      <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      go_q         <= 1'b0;
      tvalid_q     <= 1'b0;
      tlast_q      <= 1'b0;
      abort_pend_q <= 1'b0;
`ifdef SNN_STEP_SCHEDULER_ABORT_EN
      aborted_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      step_q       <= step_d;
      blk_sel_q    <= blk_sel_d;
      spike_q      <= spike_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      go_q         <= go_d;
      tvalid_q     <= tvalid_d;
      tlast_q      <= tlast_d;
      abort_pend_q <= abort_pend_d;
`ifdef SNN_STEP_SCHEDULER_ABORT_EN
      aborted_q    <= aborted_d;
`endif
    end
  end

  snn_frame_packer #(
    .N  (N),
    .T  (T),
    .NN (NN)
  ) u_packer (
    .spikes (spike_q),
    .tdata  (tdata_w)
  );

  assign busy          = busy_q;
  assign done          = done_q;
  assign blk_sel       = blk_sel_q;
  assign blk_go        = go_q & ~abort_req;
  assign m_axis.tdata  = tdata_w;
  assign m_axis.tuser  = step_q;
  assign m_axis.tvalid = tvalid_q;
  assign m_axis.tlast  = tlast_q;
`ifdef SNN_STEP_SCHEDULER_ABORT_EN
  assign aborted       = aborted_q;
`endif

endmodule

// File: doc/snn_step_scheduler.md
Name: snn_step_scheduler

Overview:
- Time-step sequencer for the SNN core. On `start`, runs TS time steps.
- Each step: triggers every neuron block in turn (0..T-1) and collects each block's N spike bits.
- Then emits one packed spike frame per step on an AXI4-Stream master, with tuser carrying the step index.
- Sits between the host/control logic and the neuron-block array; sole owner of block sequencing.

Parameters:
- N, 4, neurons per block
- T, 1, number of neuron blocks
- TS, 239, time steps per run
- TA, $clog2(T) floored at 1, block-select width
- NN, ceil(N*T/8), tdata width in bytes
- NU, $clog2(TS+1), tuser width

Ports:
- aclk  in  1  clock
- aresetn  in  1  synchronous active-low reset
- start  in  1  run request, sampled only in IDLE
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse when a run finishes
- blk_sel  out  TA  index of the block being updated
- blk_go  out  1  one-cycle update strobe to block blk_sel
- blk_done  in  1  block finished its update; valid only in WAIT
- blk_spikes  in  N  spike bits of block blk_sel, sampled with blk_done
- m_tdata  out  8*NN  spike frame, bit b*N+i = neuron i of block b, padding bits 0
- m_tuser  out  NU  step index 0..TS-1
- m_tvalid  out  1  frame valid
- m_tready  in  1  downstream ready
- m_tlast  out  1  high on the frame of step TS-1

Behaviour:
- Reset (aresetn low at a rising edge), from any state, including mid-run:
  - state becomes IDLE; busy, done, blk_go, m_tvalid, m_tlast are 0.
  - blk_sel, m_tdata, m_tuser, step counter and spike register are 0.
  - A frame already presented is withdrawn. Reset is the only permitted tvalid drop.
- FSM states: IDLE, ISSUE, WAIT, EMIT.
- IDLE:
  - start=1 -> ISSUE; step=0, blk_sel=0, spike register cleared.
  - start in any other state is ignored.
- ISSUE: blk_go=1 for exactly one cycle; -> WAIT.
- WAIT:
  - On blk_done=1, write blk_spikes into spike-register slice blk_sel.
  - If blk_sel==T-1 -> EMIT; otherwise blk_sel++ -> ISSUE.
  - blk_done in the same cycle as blk_go is not legal. blk_done outside WAIT is ignored.
  - No timeout.
- Block issue timing: minimum 2 cycles per block (ISSUE plus one WAIT cycle).
- EMIT:
  - On entry, m_tvalid=1 with m_tdata = spike register, m_tuser = step, m_tlast = (step==TS-1).
  - tdata, tuser and tlast are held stable while m_tready=0.
  - On handshake (tvalid & tready):
    - If step==TS-1: -> IDLE, done=1 next cycle.
    - Otherwise: step++, blk_sel=0, spike register cleared -> ISSUE.
  - m_tvalid deasserts in the cycle after the handshake.
- Throughput: at most one frame per 2T+1 cycles. Frames are never dropped or duplicated.
- done and a fresh start may coincide: start is accepted since the state is already IDLE.
- T=1: blk_sel is a constant 0 of width 1.

Optional Feature:
- Macro: SNN_STEP_SCHEDULER_ABORT_EN.
- When defined:
  - Adds input `abort` (1 bit) and output `aborted` (1 bit, one-cycle pulse, coincident with done).
  - abort in ISSUE or WAIT: -> IDLE next cycle; done=1 and aborted=1; blk_go suppressed.
  - abort in EMIT: latched. The current frame completes its handshake with m_tlast forced to 1, then -> IDLE with done=1 and aborted=1.
  - abort in IDLE: ignored.
- When not defined: no such ports; every run completes all TS steps.

Decomposition:
- snn_pkg supplies N, T, TA, TS, NN, NU. The module parameters default from it.
- Add to snn_pkg:
  - typedef enum sched_state_t {IDLE, ISSUE, WAIT, EMIT}
  - typedef logic [N*T-1:0] spike_frame_t
- One sub-module: snn_frame_packer, combinational. Maps spike_frame_t to the zero-padded 8*NN tdata.
- FSM, counters and spike register stay in the top module.

Test Plan (N=4, T=2, TS=3):
- Basic run, m_tready=1, blk_done 1 cycle after each go, spikes blk0=4'hA, blk1=4'h5:
  - expect 3 frames, tdata 8'h5A, tuser 0,1,2, tlast only on tuser=2.
  - done pulses once; blk_go pattern sel 0,1 per step.
- Backpressure, m_tready=0 for 5 cycles on step 1: tvalid/tdata/tuser held stable for 5 cycles; no extra blk_go issued.
- Reset mid-run, aresetn=0 for 1 cycle while in WAIT of step 1: all outputs 0 next cycle. A new start runs steps 0..2 cleanly.
- start asserted while busy: ignored; exactly 3 frames; a single done.
- Padding, N=3, T=1, spikes 3'b111: tdata=8'h07.
- With SNN_STEP_SCHEDULER_ABORT_EN:
  - abort in WAIT of step 0: no frame; done=aborted=1.
  - abort during a stalled EMIT: frame completes with tlast=1, then done=aborted=1.
